// File: rtl/scalar_writeback_unit_if.sv
// scalar_writeback_unit_if
//   Bundles every bus-level signal of the scalar writeback unit. The unit
//   itself uses the slave modport. Whatever produces results and drives the
//   decode selects uses the master modport.
//
//   Result request paths (master -> slave, except the ready lines):
//     memValid/memReg/memData, memReady   load result and its acceptance
//     aluValid/aluReg/aluData, aluReady   ALU result and its acceptance
//   Register file write port (slave -> master):
//     regWrEn, regToWrite, dataIn
//   Forwarding lookup:
//     rSel1, rSel2                        decode read selects (master -> slave)
//     fwd1Hit/fwd1Data, fwd2Hit/fwd2Data  newest pending value per select
//   Status:
//     pendingCount                        occupied FIFO entries
interface scalar_writeback_unit_if #(
  parameter int registerSize  = 8,
  parameter int selectionBits = 2,
  parameter int fifoDepth     = 4
);
  localparam int countBits = $clog2(fifoDepth) + 1;

  logic                     memValid;
  logic [selectionBits-1:0] memReg;
  logic [registerSize-1:0]  memData;
  logic                     memReady;

  logic                     aluValid;
  logic [selectionBits-1:0] aluReg;
  logic [registerSize-1:0]  aluData;
  logic                     aluReady;

  logic                     regWrEn;
  logic [selectionBits-1:0] regToWrite;
  logic [registerSize-1:0]  dataIn;

  logic [selectionBits-1:0] rSel1;
  logic [selectionBits-1:0] rSel2;
  logic                     fwd1Hit;
  logic [registerSize-1:0]  fwd1Data;
  logic                     fwd2Hit;
  logic [registerSize-1:0]  fwd2Data;

  logic [countBits-1:0]     pendingCount;

  modport master (
    output memValid, memReg, memData, aluValid, aluReg, aluData, rSel1, rSel2,
    input  memReady, aluReady, regWrEn, regToWrite, dataIn,
           fwd1Hit, fwd1Data, fwd2Hit, fwd2Data, pendingCount
  );

  modport slave (
    input  memValid, memReg, memData, aluValid, aluReg, aluData, rSel1, rSel2,
    output memReady, aluReady, regWrEn, regToWrite, dataIn,
           fwd1Hit, fwd1Data, fwd2Hit, fwd2Data, pendingCount
  );
endinterface

// File: rtl/scalar_writeback_unit.sv
// scalar_writeback_unit
//   Write-side master of the scalar register file. The unit accepts at most
//   one result per cycle from the load path or the ALU path. The load path
//   wins when both are valid. Accepted results queue in an in-order FIFO. The
//   FIFO drains one entry per cycle into a registered write stage that drives
//   the single register file write port. Decode can look up both of its read
//   selects against every pending write, so values that are still in flight
//   are visible before they are committed.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous reset, active low (0 = in reset)
//     bus    scalar_writeback_unit_if.slave: request paths, write port,
//            forwarding lookup and pending count
module scalar_writeback_unit #(
  parameter int registerSize     = 8,
  parameter int registerQuantity = 4,
  parameter int selectionBits    = 2,
  parameter int fifoDepth        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  scalar_writeback_unit_if.slave  bus
);
  localparam int ptrBits   = $clog2(fifoDepth);
  localparam int countBits = ptrBits + 1;

  // The register index must be wide enough to address every register.
  // This block is empty on purpose. Its guard records that constraint.
  if (registerQuantity > (1 << selectionBits)) begin : gSelectionTooNarrow
  end

  logic [selectionBits-1:0] fifoReg  [fifoDepth];
  logic [registerSize-1:0]  fifoData [fifoDepth];

  logic [ptrBits-1:0]       wrPtr;
  logic [ptrBits-1:0]       rdPtr;
  logic [countBits-1:0]     count;

  logic                     full;
  logic                     empty;
  logic                     memAccept;
  logic                     aluAccept;
  logic                     push;
  logic                     pop;
  logic [selectionBits-1:0] pushReg;
  logic [registerSize-1:0]  pushData;

  logic                     regWrEnQ;
  logic [selectionBits-1:0] regToWriteQ;
  logic [registerSize-1:0]  dataInQ;

  logic [ptrBits-1:0]       scanIdx;
  logic                     fwd1HitC;
  logic [registerSize-1:0]  fwd1DataC;
  logic                     fwd2HitC;
  logic [registerSize-1:0]  fwd2DataC;

  // Acceptance and arbitration.
  // Ready is taken from the current count only. A pop on the same edge does
  // not free a slot, so a full FIFO always costs one stall cycle. This keeps
  // the ready path free of the drain logic.
  always_comb begin
    full      = (count == countBits'(fifoDepth));
    empty     = (count == '0);
    memAccept = bus.memValid && !full;
    aluAccept = bus.aluValid && !full && !bus.memValid;
    push      = memAccept || aluAccept;
    pop       = !empty;
    pushReg   = memAccept ? bus.memReg  : bus.aluReg;
    pushData  = memAccept ? bus.memData : bus.aluData;
  end

  assign bus.memReady = !full;
  assign bus.aluReady = !full && !bus.memValid;

  // Pointer and occupancy bookkeeping.
  // The pointers wrap naturally because the depth is a power of two. The
  // count saturates by construction, since ready blocks any push when full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + countBits'(push) - countBits'(pop);
    end
  end

  // FIFO storage. This block has no reset. After reset the count is zero,
  // so the old contents are never looked at again.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoReg[wrPtr]  <= pushReg;
      fifoData[wrPtr] <= pushData;
    end
  end

  // Registered write stage. The head moves here whenever the FIFO holds
  // anything. When the FIFO is empty, only the enable drops. Index and data
  // keep their last values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWrEnQ    <= 1'b0;
      regToWriteQ <= '0;
      dataInQ     <= '0;
    end else if (pop) begin
      regWrEnQ    <= 1'b1;
      regToWriteQ <= fifoReg[rdPtr];
      dataInQ     <= fifoData[rdPtr];
    end else begin
      regWrEnQ    <= 1'b0;
    end
  end

  assign bus.regWrEn      = regWrEnQ;
  assign bus.regToWrite   = regToWriteQ;
  assign bus.dataIn       = dataInQ;
  assign bus.pendingCount = count;

  // Forwarding lookup.
  // The scan starts with the write stage, which is the oldest pending write.
  // It then walks the occupied FIFO entries from head to tail. Each later
  // match overrides an earlier one, so the youngest pending value wins.
  always_comb begin
    fwd1HitC  = 1'b0;
    fwd1DataC = '0;
    fwd2HitC  = 1'b0;
    fwd2DataC = '0;
    scanIdx   = '0;
    if (regWrEnQ && (regToWriteQ == bus.rSel1)) begin
      fwd1HitC  = 1'b1;
      fwd1DataC = dataInQ;
    end
    if (regWrEnQ && (regToWriteQ == bus.rSel2)) begin
      fwd2HitC  = 1'b1;
      fwd2DataC = dataInQ;
    end
    for (int i = 0; i < fifoDepth; i++) begin
      scanIdx = rdPtr + ptrBits'(i);
      if (countBits'(i) < count) begin
        if (fifoReg[scanIdx] == bus.rSel1) begin
          fwd1HitC  = 1'b1;
          fwd1DataC = fifoData[scanIdx];
        end
        if (fifoReg[scanIdx] == bus.rSel2) begin
          fwd2HitC  = 1'b1;
          fwd2DataC = fifoData[scanIdx];
        end
      end
    end
  end

  assign bus.fwd1Hit  = fwd1HitC;
  assign bus.fwd1Data = fwd1DataC;
  assign bus.fwd2Hit  = fwd2HitC;
  assign bus.fwd2Data = fwd2DataC;
endmodule
